ifu_inst_queue: RTL and testbench

Instruction prefetch queue placed directly downstream of the fetch unit and upstream of decode. It captures each fetched instruction word together with its PC when the bus reports the fetch as ready. It presents instructions to decode in order through a valid/ready handshake. It back-pressures fetch when full and drops all queued entries on a redirect (flush).

---
 rtl/ifu_inst_queue.sv | 162 ++++++++++++++++
 tb/tb_ifu_inst_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_inst_queue.sv
// ============================================================================
// ifu_inst_queue
// ----------------------------------------------------------------------------
// Instruction prefetch queue between the fetch unit and decode. Each word that
// fetch reports as ready is stored together with its PC. Words leave in order
// through a valid/ready handshake. Fetch is held off while the queue is full,
// and a redirect (flush) discards everything that is queued.
//
// Optional feature (build macro): IQ_BYPASS_EN
//   Defined   - when the queue is empty, an incoming word is shown on the
//               head outputs in the same cycle. If decode also takes it in
//               that cycle, the word is never written.
//   Undefined - no forwarding. A pushed word appears on the head one cycle
//               after the push.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   fetch word valid this cycle
//   in_ir      in   [31:0] fetched instruction word
//   in_pc      in   [31:0] PC of the fetched word
//   in_ready   out  queue accepts a word this cycle (~full & ~flush)
//   flush      in   redirect: discard all entries (synchronous, top priority)
//   out_valid  out  head entry valid
//   out_ir     out  [31:0] head instruction word (0 when nothing to show)
//   out_pc     out  [31:0] head PC (0 when nothing to show)
//   out_ready  in   decode consumes the head this cycle
//   count      out  [PTR_W:0] number of occupied entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
// ============================================================================
module ifu_inst_queue #(
    parameter int DEPTH = 4,   // entries; power of two, at least 2
    parameter int PTR_W = 2    // log2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [31:0]      out_ir,
    output logic [31:0]      out_pc,
    input  logic             out_ready,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Storage entry layout: {pc, ir}. Not reset; contents are only ever
    // observed through the pointers, which are reset.
    logic [63:0]      mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    logic        push;       // fetch handshake completes
    logic        mem_wr;     // the pushed word actually goes into storage
    logic        mem_rd;     // a stored head entry is consumed
    logic        fwd_valid;  // incoming word is shown on the head (bypass only)
    logic        fwd_take;   // forwarded word consumed without being stored
    logic [63:0] head_entry;

    assign empty      = (count_q == '0);
    assign full       = (count_q == COUNT_FULL);
    assign count      = count_q;

    // Registered full only: a pop while full frees the slot for next cycle.
    assign in_ready   = ~full & ~flush;
    assign push       = in_valid & in_ready;
    assign head_entry = mem_q[rd_ptr_q];

`ifdef IQ_BYPASS_EN
    // When the queue is empty, the incoming word is the head. in_ready is
    // already implied here, because empty excludes full and flush is checked.
    assign fwd_valid  = empty & in_valid & ~flush;
    assign fwd_take   = fwd_valid & out_ready;
`else
    assign fwd_valid  = 1'b0;
    assign fwd_take   = 1'b0;
`endif

    assign mem_wr     = push & ~fwd_take;
    // Only stored entries move rd_ptr. A consumed forwarded word leaves no
    // trace in the pointers.
    assign mem_rd     = ~empty & out_ready;
    assign out_valid  = ~empty | fwd_valid;

    always_comb begin
        out_ir = 32'd0;
        out_pc = 32'd0;
        if (!empty) begin
            out_pc = head_entry[63:32];
            out_ir = head_entry[31:0];
        end else if (fwd_valid) begin
            out_pc = in_pc;
            out_ir = in_ir;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Redirect wins over any same-cycle push or pop.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (mem_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({mem_wr, mem_rd})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write. A flush in the same cycle blocks the write through
    // in_ready, so a redirected word never lands here.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= {in_pc, in_ir};
        end
    end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Testbench for ifu_inst_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the fetch/decode buffer.
module tb_ifu_inst_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an ordered list of {pc, ir} words held by the queue.
    logic [63:0] mq[$];

    always #5 clk = ~clk;

    ifu_inst_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ir     (in_ir),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ir    (out_ir),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Drive one cycle's inputs at the falling edge; outputs settle 1 ns later.
    task automatic apply(input logic iv, input logic [31:0] ir, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Update the model with what the queue should do at the coming rising edge.
    task automatic advance();
        bit take;
        bit can_push;
        take = 0;
        if (flush) begin
            mq.delete();
        end else begin
            can_push = in_valid && (mq.size() < DEPTH);
`ifdef IQ_BYPASS_EN
            if (mq.size() == 0 && in_valid && out_ready) take = 1;
`endif
            if (!take && mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (can_push && !take) mq.push_back({in_pc, in_ir});
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 0; in_ir = 0; in_pc = 0; out_ready = 0; flush = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (count !== 3'd0)   begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1)   begin n_bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0)    begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_ir !== 32'h0) begin n_bad++; $display("FAIL reset_out_ir got=%h exp=0", out_ir); end
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 32'h13 + i, 32'(4 * i), 0, 0);
            advance();
        end
        apply(1, 32'hDEAD_BEEF, 32'h10, 0, 0);
        n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL fill_full got=%b exp=1", full); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (count !== 3'd4)    begin n_bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 32'h0, 32'h0, 1, 0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_ir !== 32'h13 + i) begin
                n_bad++;
                $display("FAIL drain_%0d got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h",
                         i, out_valid, out_pc, out_ir, 32'(4 * i), 32'h13 + i);
            end
            advance();
        end
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got empty=%b v=%b exp empty=1 v=0", empty, out_valid); end
        $display("test_fill_drain done");
    endtask

    task automatic test_back_to_back();
        apply(1, 32'h1000, 32'h200, 0, 0); advance();
        apply(1, 32'h1001, 32'h204, 0, 0); advance();
        for (int k = 0; k < 10; k++) begin
            apply(1, 32'h1002 + k, 32'h208 + 32'(4 * k), 1, 0);
            n_cmp++;
            if (count !== 3'd2 || out_pc !== 32'h200 + 32'(4 * k)) begin
                n_bad++;
                $display("FAIL b2b_%0d got count=%0d pc=%h exp count=2 pc=%h",
                         k, count, out_pc, 32'h200 + 32'(4 * k));
            end
            advance();
        end
        apply(0, 32'h0, 32'h0, 1, 0); advance();
        apply(0, 32'h0, 32'h0, 1, 0); advance();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h2000 + i, 32'h300 + 32'(4 * i), 0, 0);
            advance();
        end
        apply(1, 32'h2020, 32'h20, 1, 1);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        advance();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_clear got count=%0d empty=%b exp 0/1", count, empty); end
        advance();
        apply(1, 32'h2100, 32'h100, 0, 0); advance();
        apply(0, 32'h0, 32'h0, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_bad++; $display("FAIL flush_next got v=%b pc=%h exp v=1 pc=100", out_valid, out_pc); end
        advance();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_drain got empty=%b exp=1", empty); end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        apply(1, 32'h3000, 32'h400, 0, 0); advance();
        apply(1, 32'h3001, 32'h404, 0, 0); advance();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL areset_pre got=%0d exp=2", count); end
        #1 reset = 1'b0;   // between clock edges
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            n_bad++; $display("FAIL areset_drop got v=%b count=%0d empty=%b exp 0/0/1", out_valid, count, empty);
        end
        #1 reset = 1'b1;
        mq.delete();
        $display("test_async_reset done");
    endtask

`ifdef IQ_BYPASS_EN
    task automatic test_bypass();
        apply(1, 32'h4000, 32'h40, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || count !== 3'd0) begin
            n_bad++; $display("FAIL byp_fwd got v=%b pc=%h count=%0d exp 1/40/0", out_valid, out_pc, count);
        end
        advance();
        apply(1, 32'h4000, 32'h40, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_bad++; $display("FAIL byp_hold got v=%b pc=%h exp 1/40", out_valid, out_pc); end
        advance();
        apply(0, 32'h0, 32'h0, 0, 0);
        n_cmp++; if (count !== 3'd1 || out_pc !== 32'h40) begin n_bad++; $display("FAIL byp_store got count=%0d pc=%h exp 1/40", count, out_pc); end
        advance();
        apply(0, 32'h0, 32'h0, 1, 0); advance();
        $display("test_bypass done");
    endtask
`endif

    task automatic test_random();
        logic [63:0] exp_head;
        logic        exp_valid;
        logic [31:0] pc_next;
        int          errs_before;
        pc_next = 32'h8000;
        errs_before = n_bad;
        for (int c = 0; c < 600; c++) begin
            logic iv, ordy, fl;
            iv   = ($urandom % 4) != 0;
            // Alternate phases biased towards filling and towards draining.
            ordy = ((c / 50) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            fl   = ($urandom % 25) == 0;
            apply(iv, $urandom, pc_next, ordy, fl);
            exp_valid = (mq.size() > 0);
            exp_head  = (mq.size() > 0) ? mq[0] : 64'h0;
`ifdef IQ_BYPASS_EN
            if (mq.size() == 0 && iv && !fl) begin
                exp_valid = 1'b1;
                exp_head  = {in_pc, in_ir};
            end
`endif
            n_cmp++;
            if (out_valid !== exp_valid || {out_pc, out_ir} !== exp_head ||
                count !== 3'(mq.size()) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) ||
                in_ready !== ((mq.size() < DEPTH) && !fl)) begin
                n_bad++;
                $display("FAIL rand_%0d got v=%b pc=%h ir=%h cnt=%0d e=%b f=%b rdy=%b exp v=%b pc=%h ir=%h cnt=%0d",
                         c, out_valid, out_pc, out_ir, count, empty, full, in_ready,
                         exp_valid, exp_head[63:32], exp_head[31:0], mq.size());
            end
            if (in_valid && in_ready) pc_next = pc_next + 4;
            advance();
        end
        $display("test_random done, %0d new mismatches", n_bad - errs_before);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 0; in_ir = 0; in_pc = 0; out_ready = 0; flush = 0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef IQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
